// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// =============================================================================
// unified_mem_arbiter: shares one single-port sync RAM between fetch and data
// Rev 1.0
// =============================================================================
module unified_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_stall,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_stall,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_I = 2'd1;
  localparam logic [1:0] OWN_D = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_i;
  logic             w_unused_addr_bits;

  assign w_force_i = (r_starve_cnt == C_STARVE_MAX);

  // Data wins contention unless fetch has been denied STARVE_MAX cycles in a row.
  assign i_gnt   = ~rst & i_req & (~d_req | w_force_i);
  assign d_gnt   = ~rst & d_req & ~(i_req & w_force_i);
  assign i_stall = ~rst & i_req & ~i_gnt;
  assign d_stall = ~rst & d_req & ~d_gnt;

  assign ram_en    = i_gnt | d_gnt;
  assign ram_addr  = d_gnt ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
  assign ram_we    = (d_gnt & d_we) ? d_be : 4'b0000;
  assign ram_wdata = d_wdata;

  assign i_valid = (r_state == OWN_I);
  assign d_valid = (r_state == OWN_D);
  assign i_rdata = ram_rdata;
  assign d_rdata = ram_rdata;

  assign w_unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      if (i_gnt)
        r_state <= OWN_I;
      else if (d_gnt)
        r_state <= OWN_D;
      else
        r_state <= IDLE;

      if (i_req & ~i_gnt) begin
        if (r_starve_cnt != C_STARVE_MAX)
          r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// =============================================================================
// tb_unified_mem_arbiter: vector table + scoreboard bench for the arbiter
// Rev 1.0
// =============================================================================
module tb_unified_mem_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt, i_stall, i_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_stall, d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_stall(i_stall),
    .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_stall(d_stall), .d_valid(d_valid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port RAM with 1-cycle read latency and byte enables
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        exp_i_gnt;
    logic        exp_d_gnt;
  } vec_t;

  typedef struct {
    logic        is_write;
    logic [31:0] data;
  } pend_t;

  logic [31:0] ref_mem [2**ADDR_W];
  logic [31:0] pre [8] = '{32'h20080005, 32'h2009000C, 32'h01095020, 32'h0BADF00D,
                           32'hFFFFFFFF, 32'h12345678, 32'hCAFEBABE, 32'h0F0F0F0F};
  pend_t iq [$];
  pend_t dq [$];
  vec_t  vt [$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [3:0] be, input logic [31:0] da,
                              input logic [31:0] dd, input logic ei, input logic ed);
    vec_t v;
    v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_be = be;
    v.d_addr = da; v.d_wdata = dd; v.exp_i_gnt = ei; v.exp_d_gnt = ed;
    return v;
  endfunction

  // Entered just after a rising edge; drives, checks at the falling edge, advances one cycle.
  task automatic step(input vec_t v);
    pend_t                 p;
    logic [ADDR_W-1:0]     idx;
    logic [3:0]            exp_we;
    i_req = v.i_req; i_addr = v.i_addr;
    d_req = v.d_req; d_we = v.d_we; d_be = v.d_be; d_addr = v.d_addr; d_wdata = v.d_wdata;
    @(negedge clk);
    if (iq.size() > 0) begin
      p = iq.pop_front();
      chk("i_valid", {31'b0, i_valid}, 32'd1);
      chk("i_rdata", i_rdata, p.data);
    end else begin
      chk("i_valid_idle", {31'b0, i_valid}, 32'd0);
    end
    if (dq.size() > 0) begin
      p = dq.pop_front();
      chk("d_valid", {31'b0, d_valid}, 32'd1);
      if (!p.is_write) chk("d_rdata", d_rdata, p.data);
    end else begin
      chk("d_valid_idle", {31'b0, d_valid}, 32'd0);
    end
    exp_we = (v.exp_d_gnt && v.d_we) ? v.d_be : 4'b0000;
    chk("i_gnt", {31'b0, i_gnt}, {31'b0, v.exp_i_gnt});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, v.exp_d_gnt});
    chk("i_stall", {31'b0, i_stall}, {31'b0, v.i_req & ~v.exp_i_gnt});
    chk("d_stall", {31'b0, d_stall}, {31'b0, v.d_req & ~v.exp_d_gnt});
    chk("ram_en", {31'b0, ram_en}, {31'b0, v.exp_i_gnt | v.exp_d_gnt});
    chk("ram_we", {28'b0, ram_we}, {28'b0, exp_we});
    if (v.exp_i_gnt) begin
      idx = v.i_addr[ADDR_W+1:2];
      chk("ram_addr_i", {24'b0, ram_addr}, {24'b0, idx});
      iq.push_back('{1'b0, ref_mem[idx]});
    end
    if (v.exp_d_gnt) begin
      idx = v.d_addr[ADDR_W+1:2];
      chk("ram_addr_d", {24'b0, ram_addr}, {24'b0, idx});
      if (v.d_we) begin
        chk("ram_wdata", ram_wdata, v.d_wdata);
        for (int b = 0; b < 4; b++)
          if (v.d_be[b]) ref_mem[idx][8*b +: 8] = v.d_wdata[8*b +: 8];
        dq.push_back('{1'b1, 32'h0});
      end else begin
        dq.push_back('{1'b0, ref_mem[idx]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_i_gnt"},   {31'b0, i_gnt},   32'd0);
    chk({tag, "_d_gnt"},   {31'b0, d_gnt},   32'd0);
    chk({tag, "_i_stall"}, {31'b0, i_stall}, 32'd0);
    chk({tag, "_d_stall"}, {31'b0, d_stall}, 32'd0);
    chk({tag, "_i_valid"}, {31'b0, i_valid}, 32'd0);
    chk({tag, "_d_valid"}, {31'b0, d_valid}, 32'd0);
    chk({tag, "_ram_en"},  {31'b0, ram_en},  32'd0);
    chk({tag, "_ram_we"},  {28'b0, ram_we},  32'd0);
  endtask

  initial begin
    // Requests asserted under reset must all be gated off
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
    d_addr = 32'h0; d_wdata = 32'h0;
    #2;
    reset_checks("reset");
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 8; k++)
      vt.push_back(mk(0, 0, 1, 1, 4'hF, 32'(k * 4), pre[k], 0, 1));
    // fetch-only back-to-back
    vt.push_back(mk(1, 32'h00, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 32'h04, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 32'h08, 0, 0, 0, 0, 0, 1, 0));
    // write then read 0x54
    vt.push_back(mk(0, 0, 1, 1, 4'hF, 32'h54, 32'h00000007, 0, 1));
    vt.push_back(mk(0, 0, 1, 0, 4'h0, 32'h54, 0, 0, 1));
    // byte write into 0xFFFFFFFF then read back
    vt.push_back(mk(0, 0, 1, 1, 4'b0010, 32'h10, 32'h0000AB00, 0, 1));
    vt.push_back(mk(0, 0, 1, 0, 4'h0, 32'h10, 0, 0, 1));
    // contention: fetch wins every 4th cycle
    vt.push_back(mk(1, 32'h0C, 1, 0, 0, 32'h14, 0, 0, 1));
    vt.push_back(mk(1, 32'h0C, 1, 0, 0, 32'h18, 0, 0, 1));
    vt.push_back(mk(1, 32'h0C, 1, 0, 0, 32'h1C, 0, 0, 1));
    vt.push_back(mk(1, 32'h0C, 1, 0, 0, 32'h00, 0, 1, 0));
    vt.push_back(mk(1, 32'h14, 1, 0, 0, 32'h00, 0, 0, 1));
    vt.push_back(mk(1, 32'h14, 1, 0, 0, 32'h04, 0, 0, 1));
    vt.push_back(mk(1, 32'h14, 1, 0, 0, 32'h54, 0, 0, 1));
    vt.push_back(mk(1, 32'h14, 1, 0, 0, 32'h54, 0, 1, 0));
    vt.push_back(mk(1, 32'h18, 0, 0, 0, 32'h54, 0, 1, 0));
    // dropping i_req clears the starvation count
    vt.push_back(mk(1, 32'h00, 1, 0, 0, 32'h08, 0, 0, 1));
    vt.push_back(mk(1, 32'h00, 1, 0, 0, 32'h0C, 0, 0, 1));
    vt.push_back(mk(0, 32'h00, 1, 0, 0, 32'h10, 0, 0, 1));
    vt.push_back(mk(1, 32'h04, 1, 0, 0, 32'h14, 0, 0, 1));
    vt.push_back(mk(1, 32'h04, 1, 0, 0, 32'h18, 0, 0, 1));
    vt.push_back(mk(1, 32'h04, 1, 0, 0, 32'h1C, 0, 0, 1));
    vt.push_back(mk(1, 32'h04, 1, 1, 4'hF, 32'h1C, 32'h55AA55AA, 1, 0));
    vt.push_back(mk(0, 32'h00, 1, 1, 4'hF, 32'h1C, 32'h55AA55AA, 0, 1));
    vt.push_back(mk(0, 32'h00, 1, 0, 0, 32'h1C, 0, 0, 1));
    // idle
    for (int k = 0; k < 4; k++)
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int k = 0; k < vt.size(); k++)
      step(vt[k]);

    // Reset one cycle after a data read grant, with the starvation count at max
    step(mk(1, 32'h1C, 1, 0, 0, 32'h10, 0, 0, 1));
    step(mk(1, 32'h1C, 1, 0, 0, 32'h10, 0, 0, 1));
    step(mk(1, 32'h1C, 1, 0, 0, 32'h10, 0, 0, 1));
    #1;
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    iq.delete();
    dq.delete();
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Three data wins before fetch proves the count restarted from zero
    step(mk(1, 32'h08, 1, 0, 0, 32'h00, 0, 0, 1));
    step(mk(1, 32'h08, 1, 0, 0, 32'h04, 0, 0, 1));
    step(mk(1, 32'h08, 1, 0, 0, 32'h08, 0, 0, 1));
    step(mk(1, 32'h08, 1, 0, 0, 32'h0C, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port synchronous RAM (1-cycle read latency, byte-write-enabled) between the pipelined MIPS core's instruction-fetch port and data port. This lets a single memory macro replace the separate instruction ROM and data RAM.
Each cycle the arbiter grants at most one requester and drives the RAM. It returns read data to the owner one cycle later and produces stall signals for the pipeline. Data requests have priority, and a starvation counter guarantees forward progress on instruction fetch.

Parameters:
ADDR_W, 8, RAM word-address width (RAM depth = 2^ADDR_W words)
DATA_W, 32, data width
STARVE_MAX, 3, consecutive denied fetch cycles before fetch is forced to win

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
i_req  in  1  instruction fetch request
i_addr  in  32  fetch byte address; word index = i_addr[ADDR_W+1:2]
i_gnt  out  1  fetch accepted this cycle (combinational)
i_stall  out  1  i_req & ~i_gnt
i_valid  out  1  fetch data valid (one cycle after i_gnt)
i_rdata  out  DATA_W  fetched instruction
d_req  in  1  data access request
d_we  in  1  1 = write, 0 = read
d_be  in  4  byte enables for writes
d_addr  in  32  data byte address; word index = d_addr[ADDR_W+1:2]
d_wdata  in  DATA_W  write data
d_gnt  out  1  data access accepted this cycle (combinational)
d_stall  out  1  d_req & ~d_gnt
d_valid  out  1  read data valid / write done (one cycle after d_gnt)
d_rdata  out  DATA_W  read data
ram_en  out  1  RAM enable
ram_we  out  4  RAM byte write enables
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en

Behaviour:
- Grant (combinational, per cycle):
  - force_i = (starve_cnt == STARVE_MAX).
  - Both requesting: d wins unless force_i, in which case i wins.
  - Single requester: always granted.
  - No requesters: ram_en=0.
  - While rst is high, all grants are 0.
- RAM drive:
  - ram_en = i_gnt | d_gnt.
  - ram_addr is the granted port's word index.
  - ram_we = d_gnt&d_we ? d_be : 4'b0.
  - ram_wdata = d_wdata.
  - Instruction fetch never writes.
- Handshake:
  - A request is accepted on the rising edge where its gnt=1.
  - The requester holds req/addr/wdata stable while its stall=1.
  - The requester may present a new request in the cycle after gnt, so back-to-back issue at 1 access/cycle is allowed.
- Response tracking:
  - Registered owner state: IDLE, OWN_I, OWN_D.
  - On an edge with i_gnt the next state is OWN_I; with d_gnt it is OWN_D; otherwise IDLE.
  - i_valid = (state==OWN_I); d_valid = (state==OWN_D).
  - i_rdata and d_rdata both = ram_rdata; each is only meaningful while its valid is high.
  - d_valid also pulses for writes (write ack); d_rdata is don't-care in that case.
- Starvation counter starve_cnt, width clog2(STARVE_MAX+1):
  - Increments on each edge with i_req & ~i_gnt.
  - Clears on i_gnt or ~i_req.
  - Saturates at STARVE_MAX, never wraps.
  - Result: fetch waits at most STARVE_MAX cycles; the data port then loses exactly one cycle.
- Reset (async):
  - state=IDLE, starve_cnt=0.
  - i_valid=d_valid=0; all gnt/stall/ram_en/ram_we = 0 while rst is high.
- Reset mid-operation: an in-flight read is discarded; no valid pulse follows reset deassertion.
- Address bits outside [ADDR_W+1:2] are ignored; there is no range check.
- Single cycle latency from gnt to valid; throughput is 1 access/cycle total.

Test Plan:
1. Fetch only: i_req=1, i_addr=0x00,0x04,0x08 back-to-back with RAM preloaded 0x20080005,0x2009000C,0x01095020. Expect i_gnt=1 every cycle, i_stall=0, i_valid the next cycle with each word in order.
2. Write then read: d_we=1, d_be=4'hF, d_addr=0x54, d_wdata=0x00000007, then a read of 0x54. Expect ram_we=4'hF then 0, d_valid on both responses, and d_rdata=0x00000007.
3. Contention: i_req and d_req held high for 6 cycles, STARVE_MAX=3. Expect d_gnt for cycles 0-2, i_gnt at cycle 3 with d_stall=1, then d_gnt again; starve_cnt returns to 0 after the i_gnt.
4. Byte write: preload 0xFFFFFFFF at 0x10; write d_be=4'b0010, d_wdata=0x0000AB00; read back. Expect 0xFFFFABFF.
5. Reset mid-read: assert rst asynchronously in the cycle after a d_gnt read. Expect d_valid=0 immediately, no valid pulse after release, and starve_cnt=0.
6. Idle: both req=0 for 4 cycles. Expect ram_en=0, ram_we=0, no valid pulses.
